// File: rtl/uart_if.sv
// Byte-level and serial-pin signals of the 8N1 UART core, grouped for port connection.
interface uart_if;
    logic       TX;
    logic [7:0] TXDATA;
    logic       TXSTART;
    logic       TXBUSY;
    logic       TXDONE;
    logic       RX;
    logic [7:0] RXDATA;
    logic       RXBUSY;
    logic       RXDONE;

    modport master (
        output TXDATA, TXSTART, RX,
        input  TX, TXBUSY, TXDONE, RXDATA, RXBUSY, RXDONE
    );

    modport slave (
        input  TXDATA, TXSTART, RX,
        output TX, TXBUSY, TXDONE, RXDATA, RXBUSY, RXDONE
    );
endinterface

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: independent transmitter and receiver, each with its own bit-period counter.
module uart_core #(
    parameter int SCYCLE   = 50000000,
    parameter int BAUDRATE = 115200
) (
    input  logic  CLK,
    input  logic  RESET,
    uart_if.slave bus
);
    localparam int DIV  = SCYCLE / BAUDRATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t        tx_state_r, tx_state_s;
    logic [CW-1:0] tx_cnt_r, tx_cnt_s;
    logic [2:0]    tx_bit_r, tx_bit_s;
    logic [7:0]    tx_shift_r, tx_shift_s;
    logic          tx_r, tx_s, tx_busy_r, tx_busy_s, tx_done_r, tx_done_s;
    logic          tx_tick_s;

    state_t        rx_state_r, rx_state_s;
    logic [CW-1:0] rx_cnt_r, rx_cnt_s;
    logic [2:0]    rx_bit_r, rx_bit_s;
    logic [7:0]    rx_shift_r, rx_shift_s;
    logic [7:0]    rx_data_r, rx_data_s;
    logic          rx_busy_r, rx_busy_s, rx_done_r, rx_done_s;
    logic          rx_meta_r, rx_sync_r, rx_prev_r;
    logic          rx_tick_s, rx_fall_s;

    // Transmitter next-state: the start bit goes on the line on the accepting edge.
    always_comb begin
        tx_tick_s  = (tx_cnt_r == DIV_LAST);
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_tick_s ? '0 : tx_cnt_r + CW'(1);
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_s       = tx_r;
        tx_busy_s  = tx_busy_r;
        tx_done_s  = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                tx_cnt_s = '0;
                if (bus.TXSTART) begin
                    tx_state_s = ST_START;
                    tx_shift_s = bus.TXDATA;
                    tx_s       = 1'b0;
                    tx_busy_s  = 1'b1;
                end else begin
                    tx_s      = 1'b1;
                    tx_busy_s = 1'b0;
                end
            end
            ST_START: begin
                if (tx_tick_s) begin
                    tx_state_s = ST_DATA;
                    tx_bit_s   = 3'd0;
                    tx_s       = tx_shift_r[0];
                end else begin
                    tx_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (tx_tick_s && tx_bit_r == 3'd7) begin
                    tx_state_s = ST_STOP;
                    tx_s       = 1'b1;
                end else if (tx_tick_s) begin
                    tx_bit_s   = tx_bit_r + 3'd1;
                    tx_shift_s = {1'b0, tx_shift_r[7:1]};
                    tx_s       = tx_shift_r[1];
                end else begin
                    tx_s = tx_r;
                end
            end
            ST_STOP: begin
                if (tx_tick_s) begin
                    tx_state_s = ST_IDLE;
                    tx_busy_s  = 1'b0;
                    tx_done_s  = 1'b1;
                end else begin
                    tx_s = 1'b1;
                end
            end
            default: begin
                tx_state_s = ST_IDLE;
                tx_s       = 1'b1;
                tx_busy_s  = 1'b0;
            end
        endcase
    end

    // Transmitter registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_r       <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_r       <= tx_s;
            tx_busy_r  <= tx_busy_s;
            tx_done_r  <= tx_done_s;
        end
    end

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= bus.RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver next-state; after a framing error the edge detector needs the line high again to re-arm.
    always_comb begin
        rx_tick_s  = (rx_cnt_r == DIV_LAST);
        rx_fall_s  = rx_prev_r & ~rx_sync_r;
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_tick_s ? '0 : rx_cnt_r + CW'(1);
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        rx_data_s  = rx_data_r;
        rx_busy_s  = rx_busy_r;
        rx_done_s  = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                rx_cnt_s = '0;
                if (rx_fall_s) begin
                    rx_state_s = ST_START;
                    rx_busy_s  = 1'b1;
                end else begin
                    rx_busy_s = 1'b0;
                end
            end
            ST_START: begin
                if (rx_cnt_r == HALF_LAST && !rx_sync_r) begin
                    rx_state_s = ST_DATA;
                    rx_cnt_s   = '0;
                    rx_bit_s   = 3'd0;
                end else if (rx_cnt_r == HALF_LAST) begin
                    rx_state_s = ST_IDLE;
                    rx_cnt_s   = '0;
                    rx_busy_s  = 1'b0;
                end else begin
                    rx_cnt_s = rx_cnt_r + CW'(1);
                end
            end
            ST_DATA: begin
                if (rx_tick_s) begin
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    rx_bit_s   = rx_bit_r + 3'd1;
                    rx_state_s = (rx_bit_r == 3'd7) ? ST_STOP : ST_DATA;
                end else begin
                    rx_shift_s = rx_shift_r;
                end
            end
            ST_STOP: begin
                if (rx_tick_s) begin
                    rx_state_s = ST_IDLE;
                    rx_busy_s  = 1'b0;
                    rx_data_s  = rx_sync_r ? rx_shift_r : rx_data_r;
                    rx_done_s  = rx_sync_r;
                end else begin
                    rx_busy_s = 1'b1;
                end
            end
            default: begin
                rx_state_s = ST_IDLE;
                rx_busy_s  = 1'b0;
            end
        endcase
    end

    // Receiver registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
            rx_data_r  <= 8'd0;
            rx_busy_r  <= 1'b0;
            rx_done_r  <= 1'b0;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            rx_data_r  <= rx_data_s;
            rx_busy_r  <= rx_busy_s;
            rx_done_r  <= rx_done_s;
        end
    end

    assign bus.TX     = tx_r;
    assign bus.TXBUSY = tx_busy_r;
    assign bus.TXDONE = tx_done_r;
    assign bus.RXDATA = rx_data_r;
    assign bus.RXBUSY = rx_busy_r;
    assign bus.RXDONE = rx_done_r;
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: TX/RX vector tables, glitch and abort sequences, random duplex traffic.
module tb_uart_core;
    localparam int DIV  = 50000000 / 115200;
    localparam int HALF = DIV / 2;

    typedef struct {
        logic [7:0] d;
        logic [9:0] line;
        bit         inject;
    } tx_vec_t;

    typedef struct {
        logic [7:0] d;
        logic       stopb;
        int         exp_done;
        logic [7:0] exp_data;
    } rx_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] rx_got[$];

    uart_if bus();
    assign bus.RX = loop_en ? bus.TX : rx_drv;

    uart_core dut (.CLK(clk), .RESET(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Record every byte reported by the receiver.
    always @(negedge clk) begin
        if (bus.RXDONE === 1'b1) rx_got.push_back(bus.RXDATA);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Line sequence in time order: start 0, data LSB first, stop 1.
    function automatic logic [9:0] frame_bits(input logic [7:0] d);
        logic [9:0] f;
        f[0] = 1'b0;
        f[9] = 1'b1;
        for (int i = 1; i <= 8; i++) f[i] = ((d >> (i - 1)) & 8'd1) != 8'd0;
        return f;
    endfunction

    // Starts a frame at the current negedge and follows it cycle by cycle up to the TXDONE cycle.
    task automatic tx_frame(input logic [7:0] d, input logic [9:0] exp, input string nm, input bit inject);
        logic [9:0] mism = 10'd0;
        bus.TXDATA  = d;
        bus.TXSTART = 1'b1;
        @(negedge clk);
        bus.TXSTART = 1'b0;
        bus.TXDATA  = ~d;
        for (int k = 0; k < 10 * DIV; k++) begin
            if (bus.TX !== exp[k / DIV] || bus.TXBUSY !== 1'b1 || bus.TXDONE !== 1'b0) mism[k / DIV] = 1'b1;
            if (inject && k == 5 * DIV) begin
                bus.TXDATA  = 8'hFF;
                bus.TXSTART = 1'b1;
            end else begin
                bus.TXSTART = 1'b0;
            end
            @(negedge clk);
        end
        check({nm, "_bits"}, 32'(mism), 32'd0);
        check({nm, "_done"}, {29'd0, bus.TXDONE, bus.TXBUSY, bus.TX}, 32'b101);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stopb, output bit busy_ok);
        logic [9:0] fb;
        fb = frame_bits(d);
        fb[9] = stopb;
        busy_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rx_drv = fb[i];
            for (int k = 0; k < DIV; k++) begin
                @(negedge clk);
                if (i >= 1 && i <= 8 && k == HALF && bus.RXBUSY !== 1'b1) busy_ok = 1'b0;
            end
        end
        rx_drv = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    tx_vec_t tx_tab[3];
    rx_vec_t rx_tab[5];

    initial begin
        bit ok;
        int n0;
        logic [7:0] a, b;

        tx_tab[0] = '{8'hA5, 10'b1101001010, 1'b1};
        tx_tab[1] = '{8'h3C, 10'b1001111000, 1'b0};
        tx_tab[2] = '{8'h00, 10'b1000000000, 1'b0};
        rx_tab[0] = '{8'h5A, 1'b1, 1, 8'h5A};
        rx_tab[1] = '{8'h81, 1'b0, 0, 8'h5A};
        rx_tab[2] = '{8'h81, 1'b1, 1, 8'h81};
        rx_tab[3] = '{8'hFF, 1'b0, 0, 8'h81};
        rx_tab[4] = '{8'h00, 1'b1, 1, 8'h00};

        bus.TXDATA  = 8'h00;
        bus.TXSTART = 1'b0;

        // Reset held while inputs toggle.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rx_drv      = k[0];
            bus.TXSTART = k[1];
        end
        #1;
        check("rst_flags", {26'd0, bus.TX, bus.TXBUSY, bus.TXDONE, bus.RXBUSY, bus.RXDONE, 1'b0}, 32'b100000);
        check("rst_rxdata", 32'(bus.RXDATA), 32'd0);
        @(negedge clk);
        bus.TXSTART = 1'b0;
        rx_drv      = 1'b1;
        rst_n       = 1'b1;
        idle(20);
        check("post_rst_idle", {28'd0, bus.TX, bus.TXBUSY, bus.RXBUSY, bus.RXDONE}, 32'b1000);

        // TX table: frames chained back to back from the TXDONE cycle.
        for (int i = 0; i < 3; i++) tx_frame(tx_tab[i].d, tx_tab[i].line, $sformatf("tx%0d", i), tx_tab[i].inject);
        @(negedge clk);
        check("tx_idle_after", {30'd0, bus.TX, bus.TXBUSY}, 32'b10);

        // RX table including framing errors.
        idle(DIV);
        for (int i = 0; i < 5; i++) begin
            n0 = rx_got.size();
            rx_frame(rx_tab[i].d, rx_tab[i].stopb, ok);
            idle(DIV);
            check($sformatf("rx%0d_busy", i), 32'(ok), 32'd1);
            check($sformatf("rx%0d_done", i), 32'(rx_got.size() - n0), 32'(rx_tab[i].exp_done));
            check($sformatf("rx%0d_data", i), 32'(bus.RXDATA), 32'(rx_tab[i].exp_data));
            check($sformatf("rx%0d_idle", i), 32'(bus.RXBUSY), 32'd0);
        end

        // 100-cycle low glitch.
        n0 = rx_got.size();
        for (int k = 0; k < 300; k++) begin
            rx_drv = (k < 100) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (k == 150) check("glitch_busy", 32'(bus.RXBUSY), 32'd1);
            if (k == 260) check("glitch_drop", 32'(bus.RXBUSY), 32'd0);
        end
        check("glitch_nodone", 32'(rx_got.size() - n0), 32'd0);

        // Random full-duplex traffic against the frame model.
        for (int r = 0; r < 2; r++) begin
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 0));
            n0 = rx_got.size();
            fork
                tx_frame(a, frame_bits(a), $sformatf("rtx%0d", r), 1'b0);
                rx_frame(b, 1'b1, ok);
            join
            idle(DIV);
            check($sformatf("rrx%0d_cnt", r), 32'(rx_got.size() - n0), 32'd1);
            check($sformatf("rrx%0d_data", r), 32'(bus.RXDATA), 32'(b));
        end

        // External loopback of 0x00..0x03.
        loop_en = 1'b1;
        idle(10);
        for (int i = 0; i < 4; i++) begin
            n0 = rx_got.size();
            bus.TXDATA  = 8'(i);
            bus.TXSTART = 1'b1;
            @(negedge clk);
            bus.TXSTART = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 12 * DIV && !ok; k++) begin
                @(negedge clk);
                if (bus.TXDONE === 1'b1) ok = 1'b1;
            end
            check($sformatf("lb%0d_txdone", i), 32'(ok), 32'd1);
            check($sformatf("lb%0d_cnt", i), 32'(rx_got.size() - n0), 32'd1);
            if (rx_got.size() > n0) check($sformatf("lb%0d_data", i), 32'(rx_got[rx_got.size() - 1]), 32'(i));
            else check($sformatf("lb%0d_data", i), 32'hFFFF_FFFF, 32'(i));
        end

        // Reset in the middle of a looped-back frame.
        n0 = rx_got.size();
        bus.TXDATA  = 8'h55;
        bus.TXSTART = 1'b1;
        @(negedge clk);
        bus.TXSTART = 1'b0;
        idle(3 * DIV);
        check("abort_busy_before", {30'd0, bus.TXBUSY, bus.RXBUSY}, 32'b11);
        rst_n = 1'b0;
        #1;
        check("abort_lines", {28'd0, bus.TX, bus.TXBUSY, bus.RXBUSY, bus.RXDONE}, 32'b1000);
        idle(4);
        rst_n = 1'b1;
        idle(11 * DIV);
        check("abort_nodone", 32'(rx_got.size() - n0), 32'd0);
        check("abort_rxdata", 32'(bus.RXDATA), 32'd0);
        check("abort_idle", {30'd0, bus.TX, bus.TXBUSY}, 32'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
